hdmi_text_axi_slave: RTL and testbench

AXI4-Lite responder for the HDMI text controller: the target that the driver (or the simulation bus master) writes character/attribute words and palette entries into. It terminates all five AXI4-Lite channels. It forwards VRAM accesses to an external single-cycle-latency block RAM port and holds the 8-word colour palette internally. It also exposes a combinational palette lookup to the pixel/draw logic.

---
 rtl/hdmi_text_axi_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_hdmi_text_axi_slave.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_text_axi_slave.sv
// AXI4-Lite target for the HDMI text controller: VRAM words go out on a single-cycle BRAM port,
// the 8-word colour palette is held here and drives a combinational colour lookup.
module hdmi_text_axi_slave #(
  parameter int          C_AXI_DATA_WIDTH = 32,
  parameter int          C_AXI_ADDR_WIDTH = 16,
  parameter int          VRAM_WORDS       = 1200,
  parameter logic [11:0] PAL_BASE         = 12'h800
) (
  input  logic                          axi_aclk,
  input  logic                          axi_areset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  output logic [10:0]                   vram_addr,
  output logic                          vram_en,
  output logic [3:0]                    vram_we,
  output logic [31:0]                   vram_wdata,
  input  logic [31:0]                   vram_rdata,
  input  logic [3:0]                    vid_color_idx,
  output logic [11:0]                   vid_rgb
);
  localparam int IW = C_AXI_ADDR_WIDTH - 2;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_RAM = 2'd2, R_DATA = 2'd3} rstate_e;

  function automatic logic is_vram(input logic [IW-1:0] idx);
    return idx < IW'(VRAM_WORDS);
  endfunction

  function automatic logic is_pal(input logic [IW-1:0] idx);
    return (idx >= IW'(PAL_BASE)) && (idx < (IW'(PAL_BASE) + IW'(4'd8)));
  endfunction

  wstate_e         w_state_q, w_state_d;
  logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic            awready_q, awready_d, wready_q, wready_d;
  logic [IW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [31:0]     pal_q [8];
  logic [31:0]     pal_d [8];

  rstate_e         r_state_q, r_state_d;
  logic [IW-1:0]   raddr_q, raddr_d;
  logic            rd_issued_q, rd_issued_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  logic            wr_go_s, rd_go_s, w_err_s;
  logic [31:0]     pal_word_s;
  logic            unused_s;

  assign unused_s = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

  // Write channel: independent AW/W capture, one execute cycle, then response.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    pal_d     = pal_q;
    case (w_state_q)
      W_IDLE: begin
        if (axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          waddr_d   = axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
        end else begin
          aw_held_d = aw_held_q;
        end
        if (axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = axi_wdata;
          wstrb_d  = axi_wstrb;
        end else begin
          w_held_d = w_held_q;
        end
        if (aw_held_d && w_held_d) w_state_d = W_EXEC;
        else                       w_state_d = W_IDLE;
      end
      W_EXEC: begin
        if (is_pal(waddr_q)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) pal_d[waddr_q[2:0]][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (axi_bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Write-side state, captured request and palette storage.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      pal_q     <= '{default: 32'h0};
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      pal_q     <= pal_d;
    end
  end

  // Read channel; a VRAM read issues once and samples BRAM data on the next edge.
  always_comb begin
    r_state_d   = r_state_q;
    raddr_d     = raddr_q;
    rd_issued_d = rd_issued_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_go_s     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (axi_arvalid) r_state_d = R_ACK;
        else             r_state_d = R_IDLE;
      end
      R_ACK: begin
        raddr_d   = axi_araddr[C_AXI_ADDR_WIDTH-1:2];
        r_state_d = R_RAM;
      end
      R_RAM: begin
        if (rd_issued_q) begin
          rdata_d     = vram_rdata;
          rresp_d     = 2'b00;
          rd_issued_d = 1'b0;
          r_state_d   = R_DATA;
        end else if (w_state_q == W_EXEC) begin
          r_state_d = R_RAM;
        end else if (is_vram(raddr_q)) begin
          rd_go_s     = 1'b1;
          rd_issued_d = 1'b1;
        end else if (is_pal(raddr_q)) begin
          rdata_d   = pal_q[raddr_q[2:0]];
          rresp_d   = 2'b00;
          r_state_d = R_DATA;
        end else begin
          rdata_d   = '0;
          rresp_d   = 2'b10;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi_rready) r_state_d = R_IDLE;
        else            r_state_d = R_DATA;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read-side state and the held read response.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state_q   <= R_IDLE;
      raddr_q     <= '0;
      rd_issued_q <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
    end else begin
      r_state_q   <= r_state_d;
      raddr_q     <= raddr_d;
      rd_issued_q <= rd_issued_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  // BRAM port: the write execute cycle owns the port, reads wait for it.
  always_comb begin
    wr_go_s    = (w_state_q == W_EXEC) && is_vram(waddr_q);
    w_err_s    = !is_vram(waddr_q) && !is_pal(waddr_q);
    vram_en    = wr_go_s || rd_go_s;
    vram_we    = wr_go_s ? wstrb_q : 4'b0000;
    vram_addr  = wr_go_s ? waddr_q[10:0] : raddr_q[10:0];
    vram_wdata = wdata_q;
  end

  // Palette lookup for the draw logic: odd colours in the upper half of each word.
  always_comb begin
    pal_word_s = pal_q[vid_color_idx[3:1]];
    vid_rgb    = vid_color_idx[0] ? pal_word_s[24:13] : pal_word_s[12:1];
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = (w_state_q == W_RESP);
  assign axi_bresp   = ((w_state_q == W_RESP) && w_err_s) ? 2'b10 : 2'b00;
  assign axi_arready = (r_state_q == R_ACK);
  assign axi_rvalid  = (r_state_q == R_DATA);
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
endmodule

// File: tb/tb_hdmi_text_axi_slave.sv
// Directed and randomized bench for hdmi_text_axi_slave with a word-level memory/palette model
// and a simple read-first BRAM attached to the VRAM port.
module tb_hdmi_text_axi_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [10:0] vram_addr;
  logic        vram_en;
  logic [3:0]  vram_we;
  logic [31:0] vram_wdata, vram_rdata;
  logic [3:0]  vid_idx;
  logic [11:0] vid_rgb;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  logic [31:0] exp_vram [1200];
  logic [31:0] exp_pal [8];
  logic [31:0] bram [2048];
  bit          bram_vld [2048];

  always #5 clk = ~clk;

  hdmi_text_axi_slave dut (
    .axi_aclk(clk), .axi_areset(rst),
    .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .vram_addr(vram_addr), .vram_en(vram_en), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .vid_color_idx(vid_idx), .vid_rgb(vid_rgb)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hCAFEBABE;
    return (32'(i) * 32'h9E3779B1) + 32'h12345677;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // 0 = VRAM, 1 = palette, 2 = unmapped
  function automatic int region_of(input int word);
    if (word < 1200) return 0;
    if (word >= 2048 && word < 2056) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] bram_word(input logic [10:0] a);
    return bram_vld[a] ? bram[a] : init_val(int'(a));
  endfunction

  // Read-first BRAM with one cycle read latency.
  always @(posedge clk) begin
    if (vram_en === 1'b1) begin
      en_cnt <= en_cnt + 1;
      vram_rdata <= bram_word(vram_addr);
      if (vram_we != 4'b0000) begin
        bram[vram_addr] <= merge(bram_word(vram_addr), vram_wdata, vram_we);
        bram_vld[vram_addr] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input int idx);
    logic [31:0] w;
    @(negedge clk);
    vid_idx = 4'(idx);
    #1;
    w = exp_pal[idx / 2];
    check("vid_rgb", {20'h0, vid_rgb}, (w >> ((idx % 2 == 1) ? 13 : 1)) & 32'hFFF);
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit solo);
    int cyc, k, en0, word, region;
    bit aw_done, w_done, aw_fire, w_fire;
    word = int'(addr[15:2]);
    region = region_of(word);
    @(negedge clk);
    en0 = en_cnt;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      if (w_done && !aw_done) begin
        check("wready_after_w", {31'h0, wready}, 32'h0);
        check("awready_held", {31'h0, awready}, 32'h1);
      end
      if (aw_done && !w_done) begin
        check("awready_after_aw", {31'h0, awready}, 32'h0);
        check("wready_held", {31'h0, wready}, 32'h1);
      end
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (aw_fire) begin aw_done = 1; awvalid = 1'b0; end
      if (w_fire)  begin w_done = 1;  wvalid = 1'b0; end
    end
    check("w_handshake", {30'h0, aw_done, w_done}, 32'h3);
    if (solo) begin
      check("exec_en", {31'h0, vram_en}, (region == 0) ? 32'h1 : 32'h0);
      if (region == 0) begin
        check("exec_we", {28'h0, vram_we}, {28'h0, strb});
        check("exec_addr", {21'h0, vram_addr}, 32'(word));
        check("exec_wdata", vram_wdata, data);
      end
    end
    if (region == 0) exp_vram[word] = merge(exp_vram[word], data, strb);
    if (region == 1) exp_pal[word - 2048] = merge(exp_pal[word - 2048], data, strb);
    k = 0;
    while (!bvalid && k < 20) begin @(negedge clk); k++; end
    check("bvalid", {31'h0, bvalid}, 32'h1);
    if (solo) check("b_latency", 32'(k), 32'h1);
    check("bresp", {30'h0, bresp}, (region == 2) ? 32'h2 : 32'h0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", {31'h0, bvalid}, 32'h0);
    if (solo) check("w_bram_uses", 32'(en_cnt - en0), (region == 0) ? 32'h1 : 32'h0);
  endtask

  task automatic axi_read(input logic [15:0] addr, input int hold, input bit solo);
    int k, en0, word, region;
    logic [31:0] exp;
    word = int'(addr[15:2]);
    region = region_of(word);
    exp = (region == 0) ? exp_vram[word] : (region == 1) ? exp_pal[word - 2048] : 32'h0;
    @(negedge clk);
    en0 = en_cnt;
    arvalid = 1'b1; araddr = addr;
    k = 0;
    while (!arready && k < 20) begin @(negedge clk); k++; end
    check("arready", {31'h0, arready}, 32'h1);
    if (solo) check("ar_latency", 32'(k), 32'h1);
    @(negedge clk);
    arvalid = 1'b0;
    check("arready_pulse", {31'h0, arready}, 32'h0);
    k = 0;
    while (!rvalid && k < 20) begin @(negedge clk); k++; end
    check("rvalid", {31'h0, rvalid}, 32'h1);
    if (solo) check("r_latency", 32'(k), (region == 0) ? 32'h2 : 32'h1);
    check("rdata", rdata, exp);
    check("rresp", {30'h0, rresp}, (region == 2) ? 32'h2 : 32'h0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rvalid_hold", {31'h0, rvalid}, 32'h1);
      check("rdata_hold", rdata, exp);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_drop", {31'h0, rvalid}, 32'h0);
    if (solo) check("r_bram_uses", 32'(en_cnt - en0), (region == 0) ? 32'h1 : 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = 3'b000; arprot = 3'b000;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; vid_idx = 4'd0;
    for (int i = 0; i < 1200; i++) exp_vram[i] = init_val(i);
    for (int i = 0; i < 8; i++) exp_pal[i] = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_awready", {31'h0, awready}, 32'h0);
    check("rst_wready", {31'h0, wready}, 32'h0);
    check("rst_bvalid", {31'h0, bvalid}, 32'h0);
    check("rst_arready", {31'h0, arready}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resp", {28'h0, bresp, rresp}, 32'h0);
    check("rst_vram", {27'h0, vram_en, vram_we}, 32'h0);
    check("rst_rgb", {20'h0, vid_rgb}, 32'h0);
    rst = 1'b0;
    #1;
    check("awready_post_rst", {31'h0, awready}, 32'h0);
    @(negedge clk);
    check("awready_rise", {30'h0, awready, wready}, 32'h3);

    // VRAM write with AW and W together, then W ahead of AW at the last VRAM word
    axi_write(16'h0000, 32'h12345678, 4'hF, 0, 0, 1'b1);
    axi_write(16'(1199 * 4), 32'hA5A55A5A, 4'hF, 3, 0, 1'b1);
    axi_read(16'(1199 * 4), 0, 1'b1);
    axi_read(16'h0000, 0, 1'b1);

    // Palette word 1 holds colours 2 and 3
    axi_write(16'h2004, 32'h01FFE000, 4'hF, 0, 0, 1'b1);
    @(negedge clk); vid_idx = 4'd3; #1;
    check("rgb_idx3", {20'h0, vid_rgb}, 32'hFFF);
    vid_idx = 4'd2; #1;
    check("rgb_idx2", {20'h0, vid_rgb}, 32'h000);
    axi_write(16'h2004, 32'h00000000, 4'b0001, 1, 0, 1'b1);
    axi_read(16'h2004, 0, 1'b1);
    check_rgb(3);

    // VRAM read with held rdata, then unmapped accesses
    axi_read(16'(5 * 4), 3, 1'b1);
    axi_write(16'h4000, 32'hDEADBEEF, 4'hF, 0, 0, 1'b1);
    axi_read(16'h4000, 1, 1'b1);

    // Read lands in R_RAM exactly when the write executes
    fork
      axi_write(16'(10 * 4), 32'h600DD00D, 4'hF, 1, 1, 1'b0);
      axi_read(16'(20 * 4), 0, 1'b0);
    join
    axi_read(16'(10 * 4), 0, 1'b1);

    // Reset while the write response is pending
    @(negedge clk);
    awaddr = 16'(7 * 4); awvalid = 1'b1; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    exp_vram[7] = 32'h0BADF00D;
    @(negedge clk);
    check("pre_rst_bvalid", {31'h0, bvalid}, 32'h1);
    vid_idx = 4'd3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) exp_pal[i] = 32'h0;
    check("rstw_bvalid", {31'h0, bvalid}, 32'h0);
    check("rstw_ready", {30'h0, awready, wready}, 32'h0);
    check("rstw_rgb", {20'h0, vid_rgb}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstw_recover", {30'h0, awready, bvalid}, 32'h2);
    axi_read(16'(7 * 4), 0, 1'b1);

    // Reset while a VRAM read is on the BRAM port
    @(negedge clk);
    araddr = 16'(30 * 4); arvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("rram_en", {27'h0, vram_en, vram_we}, 32'h10);
    rst = 1'b1;
    #1;
    check("rstr_en", {31'h0, vram_en}, 32'h0);
    check("rstr_valid", {30'h0, arready, rvalid}, 32'h0);
    check("rstr_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstr_no_rvalid", {31'h0, rvalid}, 32'h0);
    axi_read(16'(30 * 4), 0, 1'b1);
    axi_write(16'h2000, 32'h00001FFE, 4'hF, 0, 2, 1'b1);
    check_rgb(0);

    // Randomized traffic over all three regions
    for (int i = 0; i < 60; i++) begin
      int r;
      int word;
      r = int'($urandom_range(0, 2));
      if (r == 0)      word = int'($urandom_range(0, 1199));
      else if (r == 1) word = 2048 + int'($urandom_range(0, 7));
      else if ($urandom_range(0, 1) == 1) word = int'($urandom_range(1200, 2047));
      else             word = int'($urandom_range(2056, 16383));
      if ($urandom_range(0, 1) == 1)
        axi_write(16'(word * 4), $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);
      else
        axi_read(16'(word * 4), int'($urandom_range(0, 2)), 1'b1);
      check_rgb(int'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
